// File: rtl/krv_mem_arb_pkg.sv
// krv_mem_arb shared types: requester ids, FSM states, defaults.
// Ports: none (package). Optional feature macro: KRV_MEM_ARB_TIMEOUT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package krv_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [1:0] ARB_ID_IF  = 2'd0;
  localparam logic [1:0] ARB_ID_DM  = 2'd1;
  localparam logic [1:0] ARB_ID_DBG = 2'd2;

  localparam int ARB_DW           = `DATA_WIDTH;
  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_TIMEOUT_CYC  = 256;

  function automatic logic [2:0] id_onehot(logic [1:0] id);
    return 3'(3'b001 << id);
  endfunction

endpackage

// File: rtl/krv_mem_arb_pick.sv
// Fixed-priority requester selector with instruction-fetch starvation override.
// Ports: if/dm/dbg req + starve in; 2-bit winner id and valid out.
module krv_mem_arb_pick
  import krv_mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       dbg_req,
  input  logic       starve,
  output logic [1:0] winner,
  output logic       valid
);

  always_comb begin
    valid  = if_req | dm_req | dbg_req;
    winner = ARB_ID_IF;
    // more than one arm may be true: first match wins
    priority case (1'b1)
      starve && if_req: winner = ARB_ID_IF;
      dbg_req:          winner = ARB_ID_DBG;
      dm_req:           winner = ARB_ID_DM;
      default:          winner = ARB_ID_IF;
    endcase
  end

endmodule

// File: rtl/krv_mem_arb.sv
// Single-outstanding arbiter: if / dm / dbg requesters onto one flash_ss port.
// Ports: cpu_clk, cpu_rst (sync, active-high); per requester X in {if,dm,dbg}:
//   X_req/we/addr/wdata/be in, X_gnt/rvalid/rdata/err out; mem_* to flash_ss.
// Optional: define KRV_MEM_ARB_TIMEOUT_EN for a response watchdog in WAIT.
module krv_mem_arb
  import krv_mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = ARB_DW,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int TIMEOUT_CYC  = ARB_TIMEOUT_CYC
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,

  input  logic            if_req,
  input  logic            if_we,
  input  logic [AW-1:0]   if_addr,
  input  logic [DW-1:0]   if_wdata,
  input  logic [DW/8-1:0] if_be,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,

  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_err,

  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_be,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [DW-1:0]   dbg_rdata,
  output logic            dbg_err,

  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  arb_state_e      state;
  logic [1:0]      owner;
  logic [3:0]      starve_cnt;

  logic [1:0]      pick_id;
  logic            pick_vld;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [BW-1:0]   sel_be;

  logic            issue_st;
  logic            busy;
  logic            tmo_hit;
  logic [2:0]      own_oh;
  logic [2:0]      gnt_oh;
  logic [2:0]      rv_oh;
  logic [2:0]      err_oh;
  logic [DW-1:0]   rsp_data;

  krv_mem_arb_pick u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .dbg_req (dbg_req),
    .starve  (starve_cnt == SLIM),
    .winner  (pick_id),
    .valid   (pick_vld)
  );

  always_comb begin
    sel_we    = if_we;
    sel_addr  = if_addr;
    sel_wdata = if_wdata;
    sel_be    = if_be;
    if (pick_id == ARB_ID_DBG) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
      sel_be    = dbg_be;
    end else if (pick_id == ARB_ID_DM) begin
      sel_we    = dm_we;
      sel_addr  = dm_addr;
      sel_wdata = dm_wdata;
      sel_be    = dm_be;
    end
  end

  assign issue_st = (state == ARB_ISSUE);
  assign busy     = issue_st | (state == ARB_WAIT);

`ifdef KRV_MEM_ARB_TIMEOUT_EN
  localparam int TW0 = $clog2(TIMEOUT_CYC + 1);
  localparam int TW  = (TW0 > 8) ? TW0 : 8;

  logic [TW-1:0] tmo_cnt;

  // counts WAIT cycles; fires once the count reaches the limit
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      tmo_cnt <= '0;
    end else if (state != ARB_WAIT) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ARB_WAIT) && !mem_rvalid &&
                   (tmo_cnt == TW'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_ID_IF;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state     <= ARB_ISSUE;
            owner     <= pick_id;
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_be    <= sel_be;
            if (pick_id == ARB_ID_IF) begin
              starve_cnt <= '0;
            end else if (if_req && starve_cnt != SLIM) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_rvalid ? ARB_IDLE : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid || tmo_hit) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // a response seen in IDLE belongs to an aborted transfer: drop it
  assign own_oh   = id_onehot(owner);
  assign gnt_oh   = {3{mem_gnt & issue_st}} & own_oh;
  assign rv_oh    = {3{(mem_rvalid & busy) | tmo_hit}} & own_oh;
  assign err_oh   = {3{tmo_hit}} & own_oh;
  assign rsp_data = tmo_hit ? '0 : mem_rdata;

  assign if_gnt     = gnt_oh[0];
  assign dm_gnt     = gnt_oh[1];
  assign dbg_gnt    = gnt_oh[2];
  assign if_rvalid  = rv_oh[0];
  assign dm_rvalid  = rv_oh[1];
  assign dbg_rvalid = rv_oh[2];
  assign if_err     = err_oh[0];
  assign dm_err     = err_oh[1];
  assign dbg_err    = err_oh[2];
  assign if_rdata   = rsp_data;
  assign dm_rdata   = rsp_data;
  assign dbg_rdata  = rsp_data;

endmodule

// File: tb/tb_krv_mem_arb.sv
// Scoreboard bench for krv_mem_arb: directed cases then random traffic.
// Reference: spec priority rules plus a word-addressed memory image.
module tb_krv_mem_arb;

  localparam int SL = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } rq_t;

  typedef struct {
    logic        rd;
    logic [31:0] data;
  } rs_t;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        req [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  be [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] rdata [3];
  logic        err [3];

  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  rq_t req_q [3][$];
  rs_t rsp_q [3][$];
  int  gnt_log [$];
  int  gnt_cyc_q [$];
  logic [31:0] sb_mem [logic [31:0]];
  logic [31:0] flash  [logic [31:0]];

  int glat_cfg = -1;
  int rlat_cfg = -1;

  always #5 clk = ~clk;

  krv_mem_arb dut (
    .cpu_clk    (clk),
    .cpu_rst    (cpu_rst),
    .if_req     (req[0]),
    .if_we      (we[0]),
    .if_addr    (addr[0]),
    .if_wdata   (wdata[0]),
    .if_be      (be[0]),
    .if_gnt     (gnt[0]),
    .if_rvalid  (rvalid[0]),
    .if_rdata   (rdata[0]),
    .if_err     (err[0]),
    .dm_req     (req[1]),
    .dm_we      (we[1]),
    .dm_addr    (addr[1]),
    .dm_wdata   (wdata[1]),
    .dm_be      (be[1]),
    .dm_gnt     (gnt[1]),
    .dm_rvalid  (rvalid[1]),
    .dm_rdata   (rdata[1]),
    .dm_err     (err[1]),
    .dbg_req    (req[2]),
    .dbg_we     (we[2]),
    .dbg_addr   (addr[2]),
    .dbg_wdata  (wdata[2]),
    .dbg_be     (be[2]),
    .dbg_gnt    (gnt[2]),
    .dbg_rvalid (rvalid[2]),
    .dbg_rdata  (rdata[2]),
    .dbg_err    (err[2]),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic fail(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    bad++;
    $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                        logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sb_rd(logic [31:0] a);
    return sb_mem.exists(a) ? sb_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] fl_rd(logic [31:0] a);
    return flash.exists(a) ? flash[a] : init_word(a);
  endfunction

  // winner from the rules: if when starved, else dbg > dm > if
  function automatic int ref_pick(logic [2:0] rv, int s);
    if (s == SL && rv[0]) return 0;
    if (rv[2]) return 2;
    if (rv[1]) return 1;
    return 0;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int g, r;
    logic [31:0] d;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !cpu_rst) begin
        g = (glat_cfg < 0) ? int'($urandom_range(2, 0)) : glat_cfg;
        r = (rlat_cfg < 0) ? int'($urandom_range(3, 0)) : rlat_cfg;
        repeat (g) begin @(posedge clk); #1; end
        mem_gnt = 1'b1;
        d = fl_rd(mem_addr);
        if (mem_we) flash[mem_addr] = merge(d, mem_wdata, mem_be);
        if (r == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = d;
        end
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (r > 0) begin
          repeat (r - 1) begin @(posedge clk); #1; end
          mem_rvalid = 1'b1;
          mem_rdata = d;
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int sc = 0;
  int owner_m = 0;
  logic prev_mreq = 1'b0;
  logic [2:0] prev_rv = 3'b0;
  logic [2:0] gv;
  int last_iss_cyc, last_gnt_cyc, last_rv_cyc, last_rv_id;
  logic [31:0] last_rdata;
  int rv_cnt [3] = '{0, 0, 0};
  rq_t h;
  rs_t e;

  always @(negedge clk) begin
    cyc++;
    gv = {gnt[2], gnt[1], gnt[0]};
    if (cpu_rst) begin
      for (int k = 0; k < 3; k++) rsp_q[k].delete();
      sc = 0;
      prev_mreq = 1'b0;
    end else begin
      if (mem_req && !prev_mreq) begin
        owner_m = ref_pick(prev_rv, sc);
        if (owner_m == 0) sc = 0;
        else if (prev_rv[0] && sc < SL) sc = sc + 1;
        last_iss_cyc = cyc;
        if (req_q[owner_m].size() == 0) begin
          fail("issue_noreq", 32'(owner_m), 32'hffffffff);
        end else begin
          h = req_q[owner_m][0];
          chk("issue_addr", mem_addr, h.addr);
          chk("issue_we", 32'(mem_we), 32'(h.we));
          chk("issue_wdata", mem_wdata, h.wdata);
          chk("issue_be", 32'(mem_be), 32'(h.be));
        end
      end
      if (mem_req && mem_gnt) begin
        chk("gnt_vec", 32'(gv), 32'(3'b001 << owner_m));
        for (int k = 0; k < 3; k++) if (gv[k]) gnt_log.push_back(k);
        gnt_cyc_q.push_back(cyc);
        last_gnt_cyc = cyc;
        if (req_q[owner_m].size() > 0) begin
          h = req_q[owner_m].pop_front();
          e.rd = !h.we;
          e.data = sb_rd(h.addr);
          if (h.we) sb_mem[h.addr] = merge(e.data, h.wdata, h.be);
          rsp_q[owner_m].push_back(e);
        end
      end else if (gv != 3'b0) begin
        fail("gnt_spurious", 32'(gv), 32'h0);
      end
      for (int k = 0; k < 3; k++) begin
        if (rvalid[k]) begin
          if (rsp_q[k].size() == 0) begin
            fail("rvalid_spurious", 32'(k), 32'hffffffff);
          end else begin
            e = rsp_q[k].pop_front();
            if (e.rd) chk("rdata", rdata[k], e.data);
            chk("err", 32'(err[k]), 32'h0);
            rv_cnt[k]++;
            last_rv_cyc = cyc;
            last_rv_id = k;
            last_rdata = rdata[k];
          end
        end
      end
      prev_mreq = mem_req;
    end
    prev_rv = {req[2], req[1], req[0]};
  end

  // ---------------- requester side ----------------
  task automatic issue(int k, logic w, logic [31:0] a, logic [31:0] d,
                       logic [3:0] b);
    rq_t r;
    int n;
    r.we = w;
    r.addr = a;
    r.wdata = d;
    r.be = b;
    req_q[k].push_back(r);
    req[k] = 1'b1;
    we[k] = w;
    addr[k] = a;
    wdata[k] = d;
    be[k] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[k] && n < 300);
    if (!gnt[k]) fail("gnt_timeout", 32'(k), 32'h1);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic rand_agent(int k);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      issue(k, 1'($urandom_range(1, 0)),
            32'($urandom_range(15, 0)) << 2, $urandom,
            4'($urandom_range(15, 1)));
    end
  endtask

  task automatic settle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c2;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      we[k] = 1'b0;
      addr[k] = 32'h0;
      wdata[k] = 32'h0;
      be[k] = 4'h0;
    end
    cpu_rst = 1'b1;
    settle(3);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_gnt", 32'({gnt[2], gnt[1], gnt[0]}), 32'h0);
    chk("rst_rvalid", 32'({rvalid[2], rvalid[1], rvalid[0]}), 32'h0);
    @(posedge clk); #1;
    cpu_rst = 1'b0;
    settle(1);

    // single read, 1-cycle gnt and 1-cycle response
    glat_cfg = 1;
    rlat_cfg = 1;
    flash[32'h100] = 32'hCAFEF00D;
    sb_mem[32'h100] = 32'hCAFEF00D;
    c0 = rv_cnt[0];
    c2 = rv_cnt[2];
    issue(1, 1'b0, 32'h100, 32'h0, 4'hf);
    settle(3);
    chk("single_gnt_lat", 32'(last_gnt_cyc - last_iss_cyc), 32'd1);
    chk("single_rv_lat", 32'(last_rv_cyc - last_gnt_cyc), 32'd1);
    chk("single_rv_id", 32'(last_rv_id), 32'd1);
    chk("single_rdata", last_rdata, 32'hCAFEF00D);
    chk("single_others", 32'(rv_cnt[0] - c0 + rv_cnt[2] - c2), 32'd0);

    // simultaneous requests: dbg, dm, if
    gnt_log.delete();
    fork
      issue(0, 1'b0, 32'h200, 32'h0, 4'hf);
      issue(1, 1'b1, 32'h204, 32'h11223344, 4'h5);
      issue(2, 1'b0, 32'h208, 32'h0, 4'hf);
    join
    settle(3);
    chk("simul_cnt", 32'(gnt_log.size()), 32'd3);
    if (gnt_log.size() == 3) begin
      chk("simul_0", 32'(gnt_log[0]), 32'd2);
      chk("simul_1", 32'(gnt_log[1]), 32'd1);
      chk("simul_2", 32'(gnt_log[2]), 32'd0);
    end

    // dm hogging with if pending: 4 dm grants then if
    gnt_log.delete();
    fork
      issue(0, 1'b0, 32'h10, 32'h0, 4'hf);
      repeat (6) issue(1, 1'b0, 32'h14, 32'h0, 4'hf);
    join
    settle(3);
    chk("starve_cnt", 32'(gnt_log.size()), 32'd7);
    if (gnt_log.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        chk("starve_order", 32'(gnt_log[i]), (i == 4) ? 32'd0 : 32'd1);
    end

    // zero-latency memory
    glat_cfg = 0;
    rlat_cfg = 0;
    gnt_cyc_q.delete();
    issue(1, 1'b0, 32'h20, 32'h0, 4'hf);
    issue(1, 1'b1, 32'h24, 32'hA5A5A5A5, 4'hc);
    settle(3);
    chk("zl_cnt", 32'(gnt_cyc_q.size()), 32'd2);
    if (gnt_cyc_q.size() == 2)
      chk("zl_spacing", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 32'd2);
    chk("zl_same_cycle", 32'(last_rv_cyc - last_gnt_cyc), 32'd0);

    // reset during WAIT, stale response arrives later
    glat_cfg = 1;
    rlat_cfg = 5;
    c0 = rv_cnt[1];
    issue(1, 1'b0, 32'h30, 32'h0, 4'hf);
    cpu_rst = 1'b1;
    @(posedge clk); #1;
    cpu_rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("rst_wait_rv", 32'({rvalid[2], rvalid[1], rvalid[0]}), 32'h0);
      chk("rst_wait_req", 32'(mem_req), 32'h0);
    end
    chk("rst_wait_cnt", 32'(rv_cnt[1] - c0), 32'd0);
    @(posedge clk); #1;

    // random traffic
    glat_cfg = -1;
    rlat_cfg = -1;
    fork
      rand_agent(0);
      rand_agent(1);
      rand_agent(2);
    join
    settle(10);
    for (int k = 0; k < 3; k++) begin
      chk("end_req_q", 32'(req_q[k].size()), 32'd0);
      chk("end_rsp_q", 32'(rsp_q[k].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
